// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths common to pe_unit and its feeder,
// plus the feeder state encoding.
package npu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StArm,
    StHold,
    StDrain,
    StDone
  } feeder_state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Job, operand-stream, PE-drive and result signals of one pe_feeder.
// master is the feeder side; slave is everything around it.
interface pe_feeder_if;
    import npu_pkg::*;

    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     busy;

    logic                     op_valid;
    logic                     op_ready;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;

    logic                     pe_rst_n;
    logic                     pe_ready;
    logic signed [DATA_W-1:0] pe_a;
    logic signed [DATA_W-1:0] pe_b;
    logic signed [ACC_W-1:0]  pe_outdata;

    logic                     res_valid;
    logic                     res_ready;
    logic signed [ACC_W-1:0]  res_data;

    modport master (
        input  start, len, op_valid, op_a, op_b, pe_outdata, res_ready,
        output busy, op_ready, pe_rst_n, pe_ready, pe_a, pe_b, res_valid, res_data
    );

    modport slave (
        output start, len, op_valid, op_a, op_b, pe_outdata, res_ready,
        input  busy, op_ready, pe_rst_n, pe_ready, pe_a, pe_b, res_valid, res_data
    );

endinterface

// File: rtl/pe_feeder.sv
// Sequences one MAC PE through a dot-product job: clear, then per pair
// fetch/arm/hold, then capture the accumulator and offer it downstream.
module pe_feeder
    import npu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    pe_feeder_if.master  io_bus
);

    feeder_state_e            r_state;
    feeder_state_e            w_state_nxt;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_cnt;
    logic [LEN_W-1:0]         w_cnt_inc;
    logic signed [DATA_W-1:0] r_pe_a;
    logic signed [DATA_W-1:0] r_pe_b;
    logic signed [ACC_W-1:0]  r_res;

    assign w_cnt_inc = r_cnt + LEN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (io_bus.start) w_state_nxt = StClear;
            StClear: w_state_nxt = (r_len == '0) ? StDrain : StFetch;
            StFetch: if (io_bus.op_valid) w_state_nxt = StArm;
            StArm:   w_state_nxt = StHold;
            StHold:  w_state_nxt = (w_cnt_inc == r_len) ? StDrain : StFetch;
            StDrain: w_state_nxt = StDone;
            StDone:  if (io_bus.res_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_len   <= '0;
            r_cnt   <= '0;
            r_pe_a  <= '0;
            r_pe_b  <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == StIdle && io_bus.start) begin
                r_len <= io_bus.len;
                r_cnt <= '0;
            end
            // Operands stay put through ARM and HOLD, the PE's compute cycle.
            if (r_state == StFetch && io_bus.op_valid) begin
                r_pe_a <= io_bus.op_a;
                r_pe_b <= io_bus.op_b;
            end
            if (r_state == StHold) r_cnt <= w_cnt_inc;
            if (r_state == StDrain) r_res <= io_bus.pe_outdata;
        end
    end

    assign io_bus.busy      = (r_state != StIdle);
    assign io_bus.op_ready  = (r_state == StFetch);
    assign io_bus.pe_ready  = (r_state == StArm);
    assign io_bus.res_valid = (r_state == StDone);
    // The PE is cleared both by system reset and at the start of every job.
    assign io_bus.pe_rst_n  = rst_n && (r_state != StClear);
    assign io_bus.pe_a      = r_pe_a;
    assign io_bus.pe_b      = r_pe_b;
    assign io_bus.res_data  = r_res;

endmodule

// File: doc/pe_feeder.md
# pe_feeder

Sequencer that drives one MAC processing element through a dot-product job and collects the result. It accepts a job of `len` operand pairs, pulls them from an upstream valid/ready stream, and clears the PE accumulator through its reset. It pulses the PE's `ready` once per pair, holds operands through the PE's compute cycle, and returns the final accumulator value on a valid/ready result port. It sits between the operand buffers and each `pe_unit` in the array.

## Interface
- `DATA_W`, 8: operand width, signed.
- `ACC_W`, 24: PE accumulator/result width.
- `LEN_W`, 8: job length counter width.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; latched with `start`; 0 is legal.
- `busy`  out  1  high whenever state ≠ IDLE.
- `op_valid`  in  1  upstream operand pair valid.
- `op_ready`  out  1  feeder accepts a pair; high only in FETCH.
- `op_a`, `op_b`  in  DATA_W  signed operands.
- `pe_rst_n`  out  1  PE synchronous reset; low when `rst_n` is low or state = CLEAR.
- `pe_ready`  out  1  PE start strobe; high only in ARM.
- `pe_a`, `pe_b`  out  DATA_W  registered operands to PE.
- `pe_outdata`  in  ACC_W  PE accumulator.
- `res_valid`  out  1  result valid; high only in DONE.
- `res_ready`  in  1  downstream accepts result.
- `res_data`  out  ACC_W  registered result.

## Operation
- PE protocol being driven:
  - PE samples `ready` while idle and computes on the next cycle.
  - It adds `in_data1*in_data2` present during that compute cycle.
  - The new accumulator is visible the cycle after compute.
  - The accumulator clears only via its synchronous reset.
  - `ready` during the compute cycle is ignored.
- States: IDLE, CLEAR, FETCH, ARM, HOLD, DRAIN, DONE.
  - IDLE: on `start`, latch `len` into `len_q` and clear `cnt`; go to CLEAR. Otherwise stay.
  - CLEAR: `pe_rst_n`=0 for exactly one cycle. Go to DRAIN if `len_q`=0, else FETCH.
  - FETCH: `op_ready`=1. On `op_valid`, register `op_a`/`op_b` into `pe_a`/`pe_b` and go to ARM. Otherwise wait indefinitely.
  - ARM: `pe_ready`=1; go to HOLD.
  - HOLD: `pe_a`/`pe_b` are held (the PE compute cycle). Set `cnt`<=`cnt`+1. Go to DRAIN if `cnt`+1 = `len_q`, else FETCH.
  - DRAIN: `res_data` <= `pe_outdata`; go to DONE.
  - DONE: `res_valid`=1. On `res_ready`, go to IDLE. Hold `res_data` stable until then.
- Arithmetic:
  - The feeder performs no arithmetic on data; `res_data` is the PE's accumulator verbatim, two's complement.
  - The PE wraps modulo 2^ACC_W.
  - With DATA_W=8, ACC_W=24, any `len` ≤ 511 cannot overflow (511·16384 < 2^23).
- Boundaries:
  - `start` outside IDLE is ignored.
  - `len`=0 returns 0.
  - `op_valid` stalls stretch FETCH only; ARM and HOLD are never stalled.
  - `res_ready` low holds DONE indefinitely.
- Reset:
  - `rst_n` low in any state: state is IDLE and `cnt`, `len_q`, `pe_a`, `pe_b`, `res_data` are 0.
  - `busy`, `op_ready`, `pe_ready`, `res_valid` are 0.
  - `pe_rst_n` is 0 during reset, so the PE is cleared too.
  - An in-flight job is discarded with no result.

## Timing
- All state and data outputs are registered.
- Strobes are Moore decodes of the state; `pe_rst_n` is also gated by `rst_n`.
- Reset values: all outputs 0, including `pe_rst_n`.
- With `start` sampled at cycle 0 and `op_valid` always high:
  - CLEAR at cycle 1.
  - Pair k (k=0..N−1): FETCH at 2+3k, ARM at 3+3k, HOLD at 4+3k.
  - DRAIN at 3N+2.
  - `res_valid` first high at 3N+3.
  - `len`=0 gives `res_valid` at cycle 3.
- Throughput is one MAC per 3 cycles. Each FETCH stall cycle adds 1 cycle.
- Earliest next `start` is sampled the cycle after the `res_valid`&&`res_ready` handshake.

## Structure
- Shared package `npu_pkg` holds:
  - the state enum encoding;
  - DATA_W/ACC_W defaults, shared with `pe_unit`.
- Single module, no sub-module. The PE is instantiated beside the feeder by the array parent, not inside the feeder.

## Test plan
- `len`=3, pairs (2,3), (−4,5), (7,−1), `op_valid` always 1, `res_ready`=1 → `res_data`=−21; `res_valid` at cycle 12; exactly 3 `pe_ready` pulses and 1 `pe_rst_n` low cycle.
- `len`=0 → `res_data`=0 at cycle 3; `op_ready` and `pe_ready` never asserted.
- Back-to-back jobs: `len`=2 of (127,127) gives 32258, then `len`=1 of (−128,−128) gives 16384, proving the clear between jobs.
- `op_valid` low 4 cycles before the second pair of `len`=2 → result correct, `res_valid` delayed by 4 cycles; `pe_a`/`pe_b` stable through each HOLD.
- `res_ready` low 5 cycles in DONE → `res_valid`/`res_data` held; `start` pulses during `busy` are ignored.
- `rst_n` low for 1 cycle mid-job at `len`=5 → all outputs 0 next cycle; a new `len`=1 job of (3,3) returns 9.
